// File: rtl/bcd7_scan_driver_if.sv
// Peripheral bus bundle for the 4-digit 7-segment scan driver.
// The CPU side drives the master modport; the display controller takes the slave modport.
interface bcd7_scan_driver_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output wr_en,
    output rd_en,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  wr_en,
    input  rd_en,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/bcd7_scan_driver.sv
// Memory-mapped 4-digit 7-segment display controller: CTRL/DATA/RAW registers,
// a prescaled digit scanner and a registered active-low {AN, DP, G..A} output bus.
module bcd7_scan_driver #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0010,
  parameter int unsigned SCAN_DIV  = 50000
) (
  input  logic                clk,
  input  logic                reset,
  bcd7_scan_driver_if.slave   bus,
  output logic [11:0]         BCD7
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);

  localparam logic [1:0] OFS_CTRL = 2'd0;
  localparam logic [1:0] OFS_DATA = 2'd1;
  localparam logic [1:0] OFS_RAW  = 2'd2;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  // Register file
  logic          r_en;
  logic          r_mode;
  logic [3:0]    r_dp_mask;
  logic [15:0]   r_hex;
  logic [11:0]   r_raw;
  logic [31:0]   r_rdata;

  // Scanner state
  digit_e        r_idx;
  digit_e        w_idx_next;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_next;

  // Output path
  logic [11:0]   r_bcd7;
  logic [11:0]   w_bcd7_next;
  logic [3:0]    w_an;
  logic [3:0]    w_nibble;
  logic          w_dp_on;

  // Bus decode
  logic          w_hit;
  logic [1:0]    w_sel;
  logic          w_wr;
  logic [31:0]   w_rd_mux;
  logic          w_unused;

  assign w_hit = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_sel = bus.addr[3:2];
  assign w_wr  = bus.wr_en & w_hit;

  // Byte-lane bits below addr[2] and the undefined upper write bits carry no meaning here.
  assign w_unused = ^{bus.addr[1:0], bus.wdata[31:16], bus.wdata[3:2]};

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_en      <= 1'b0;
      r_mode    <= 1'b0;
      r_dp_mask <= '0;
      r_hex     <= '0;
      r_raw     <= '0;
    end else if (w_wr) begin
      case (w_sel)
        OFS_CTRL: begin
          r_en      <= bus.wdata[0];
          r_mode    <= bus.wdata[1];
          r_dp_mask <= bus.wdata[7:4];
        end
        OFS_DATA: r_hex <= bus.wdata[15:0];
        OFS_RAW:  r_raw <= bus.wdata[11:0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    if (w_hit) begin
      case (w_sel)
        OFS_CTRL: w_rd_mux = {24'h0, r_dp_mask, 2'b00, r_mode, r_en};
        OFS_DATA: w_rd_mux = {16'h0, r_hex};
        OFS_RAW:  w_rd_mux = {20'h0, r_raw};
        default:  w_rd_mux = '0;
      endcase
    end
  end

  // Mux sees the registers before this edge's write, so a same-cycle read returns the old value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (bus.rd_en) begin
      r_rdata <= w_rd_mux;
    end
  end

  assign bus.rdata = r_rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_presc <= '0;
      r_idx   <= DIG0;
    end else begin
      r_presc <= w_presc_next;
      r_idx   <= w_idx_next;
    end
  end

  // Holding the scanner at 0 while disabled gives digit 0 a full dwell after re-enable.
  always_comb begin
    w_presc_next = r_presc;
    w_idx_next   = r_idx;
    if (!r_en) begin
      w_presc_next = '0;
      w_idx_next   = DIG0;
    end else if (r_presc == PRESC_TC) begin
      w_presc_next = '0;
      case (r_idx)
        DIG0:    w_idx_next = DIG1;
        DIG1:    w_idx_next = DIG2;
        DIG2:    w_idx_next = DIG3;
        default: w_idx_next = DIG0;
      endcase
    end else begin
      w_presc_next = r_presc + 1'b1;
    end
  end

  always_comb begin
    w_an     = 4'b1110;
    w_nibble = r_hex[3:0];
    w_dp_on  = r_dp_mask[0];
    case (r_idx)
      DIG0: begin
        w_an     = 4'b1110;
        w_nibble = r_hex[3:0];
        w_dp_on  = r_dp_mask[0];
      end
      DIG1: begin
        w_an     = 4'b1101;
        w_nibble = r_hex[7:4];
        w_dp_on  = r_dp_mask[1];
      end
      DIG2: begin
        w_an     = 4'b1011;
        w_nibble = r_hex[11:8];
        w_dp_on  = r_dp_mask[2];
      end
      default: begin
        w_an     = 4'b0111;
        w_nibble = r_hex[15:12];
        w_dp_on  = r_dp_mask[3];
      end
    endcase

    w_bcd7_next = '1;
    if (r_en) begin
      if (r_mode) begin
        w_bcd7_next = r_raw;
      end else begin
        w_bcd7_next = {w_an, ~w_dp_on, seg_decode(w_nibble)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bcd7 <= '1;
    end else begin
      r_bcd7 <= w_bcd7_next;
    end
  end

  assign BCD7 = r_bcd7;

endmodule

// File: tb/tb_bcd7_scan_driver.sv
// Self-checking bench for bcd7_scan_driver with a fast scan (4 cycles per digit):
// table-driven hex scan vectors plus hand-written register/reset sequences.
module tb_bcd7_scan_driver;

  localparam logic [31:0] A_CTRL = 32'h4000_0010;
  localparam logic [31:0] A_DATA = 32'h4000_0014;
  localparam logic [31:0] A_RAW  = 32'h4000_0018;
  localparam logic [31:0] A_RSVD = 32'h4000_001C;

  logic        clk;
  logic        reset;
  logic [11:0] BCD7;

  bcd7_scan_driver_if bus ();

  bcd7_scan_driver #(
    .BASE_ADDR(32'h4000_0010),
    .SCAN_DIV (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .BCD7 (BCD7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]       hex;
    logic [3:0]        dp;
    logic [3:0][11:0]  exp;
  } vec_t;

  vec_t        tbl [4];
  logic [11:0] exp_q [$];
  int          n_checks;
  int          n_fail;
  logic [31:0] rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Each queued entry is the BCD7 value expected after one more clock edge.
  task automatic drain(input string name);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check(name, {20'h0, BCD7}, {20'h0, exp_q.pop_front()});
    end
  endtask

  task automatic push_n(input logic [11:0] v, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(v);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.rd_en = 1'b1;
    bus.addr  = a;
    @(negedge clk);
    bus.rd_en = 1'b0;
    d = bus.rdata;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    tbl[0] = '{hex: 16'h1234, dp: 4'b0000, exp: {12'h7F9, 12'hBA4, 12'hDB0, 12'hE99}};
    tbl[1] = '{hex: 16'hF0A8, dp: 4'b0101, exp: {12'h78E, 12'hB40, 12'hD88, 12'hE00}};
    tbl[2] = '{hex: 16'h567B, dp: 4'b1010, exp: {12'h712, 12'hB82, 12'hD78, 12'hE83}};
    tbl[3] = '{hex: 16'h9CDE, dp: 4'b1111, exp: {12'h710, 12'hB46, 12'hD21, 12'hE06}};

    reset     = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;

    // Reset for two edges, then idle: display stays blank.
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    push_n(12'hFFF, 100);
    drain("idle_blank");
    bus_read(A_CTRL, rd);
    check("reset_ctrl", rd, 32'h0);

    // Hex scan vectors, each started from a disabled scanner.
    for (int r = 0; r < 4; r++) begin
      bus_write(A_CTRL, 32'h0);
      bus_write(A_DATA, {16'h0, tbl[r].hex});
      bus_write(A_CTRL, {24'h0, tbl[r].dp, 4'h1});
      for (int rep = 0; rep < 2; rep++)
        for (int d = 0; d < 4; d++)
          push_n(tbl[r].exp[d], 4);
      drain("hex_scan");
    end

    // Raw mode.
    bus_write(A_RAW, 32'h0000_05A5);
    bus_write(A_CTRL, 32'h3);
    push_n(12'h5A5, 8);
    drain("raw_static");
    bus_read(A_RAW, rd);
    check("raw_readback", rd, 32'h0000_05A5);

    // Mid-scan DATA change on digit 2, then disable and re-enable.
    bus_write(A_CTRL, 32'h0);
    bus_write(A_DATA, 32'h0000_1234);
    bus_write(A_CTRL, 32'h1);
    push_n(12'hE99, 4);
    push_n(12'hDB0, 4);
    drain("pre_midscan");
    bus_write(A_DATA, 32'h0);
    check("midscan_old", {20'h0, BCD7}, 32'h0000_0BA4);
    push_n(12'hBC0, 3);
    push_n(12'h7C0, 4);
    push_n(12'hEC0, 4);
    drain("midscan_new");
    bus_write(A_CTRL, 32'h0);
    push_n(12'hFFF, 3);
    drain("disable_blank");
    bus_write(A_CTRL, 32'h1);
    push_n(12'hEC0, 4);
    push_n(12'hDC0, 4);
    drain("reenable_dwell");

    // Same-cycle read and write of DATA.
    bus_write(A_DATA, 32'h0000_1234);
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.addr  = A_DATA;
    bus.wdata = 32'h0000_BEEF;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("rw_same_cycle", bus.rdata, 32'h0000_1234);
    bus_read(A_DATA, rd);
    check("rw_next_read", rd, 32'h0000_BEEF);
    bus_write(A_CTRL, 32'h0);
    check("rdata_hold", bus.rdata, 32'h0000_BEEF);

    // Writes outside the register set must not change anything.
    bus_write(A_RSVD, 32'hFFFF_FFFF);
    bus_write(32'h4000_0020, 32'hFFFF_FFFF);
    bus_write(32'h4000_0000, 32'hFFFF_FFFF);
    bus_read(A_CTRL, rd);
    check("ignored_ctrl", rd, 32'h0);
    bus_read(A_DATA, rd);
    check("ignored_data", rd, 32'h0000_BEEF);
    bus_read(A_RAW, rd);
    check("ignored_raw", rd, 32'h0000_05A5);
    bus_read(A_RSVD, rd);
    check("read_rsvd", rd, 32'h0);
    bus_read(A_RAW, rd);
    bus_read(32'h4000_0024, rd);
    check("read_outside", rd, 32'h0);

    // Misaligned access decodes by addr[3:2].
    bus_write(32'h4000_0015, 32'h0000_4321);
    bus_read(32'h4000_0017, rd);
    check("misaligned", rd, 32'h0000_4321);

    // Reset asserted mid-dwell together with a write.
    bus_write(A_CTRL, 32'h1);
    push_n(12'hEF9, 4);
    push_n(12'hDA4, 2);
    drain("pre_reset_scan");
    reset     = 1'b0;
    bus.wr_en = 1'b1;
    bus.addr  = A_DATA;
    bus.wdata = 32'h0000_1111;
    @(negedge clk);
    check("reset_blank", {20'h0, BCD7}, 32'h0000_0FFF);
    check("reset_rdata", bus.rdata, 32'h0);
    bus.wr_en = 1'b0;
    reset     = 1'b1;
    bus_read(A_CTRL, rd);
    check("post_reset_ctrl", rd, 32'h0);
    bus_read(A_DATA, rd);
    check("post_reset_data", rd, 32'h0);
    bus_read(A_RAW, rd);
    check("post_reset_raw", rd, 32'h0);
    push_n(12'hFFF, 10);
    drain("post_reset_blank");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
